// File: rtl/time_digit_chain.sv
// Mixed-radix BCD up/down digit chain for the stopwatch/timer datapath.
// Optional saturating countdown mode: define TIME_DIGIT_CHAIN_SAT_EN.
module time_digit_chain #(
  parameter int              NDIG        = 6,
  parameter logic [NDIG-1:0] RADIX6_MASK = 6'b101000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                ud,
  input  logic                clr,
  input  logic                ld,
  input  logic [4*NDIG-1:0]   din,
  output logic [4*NDIG-1:0]   q,
  output logic                rco,
  output logic                wrap_p
);

  logic [NDIG-1:0][3:0] cnt;
  logic [NDIG-1:0][3:0] nxt_step;
  logic [NDIG-1:0]      term;
  logic [NDIG-1:0]      en;
  logic                 wrap_r;

  function automatic logic [3:0] dmax(input int i);
    return RADIX6_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [3:0] clamp(input logic [3:0] d, input int i);
    return (d > dmax(i)) ? dmax(i) : d;
  endfunction

  // Terminal detect per digit follows ud combinationally; carry ripples in one cycle
  always_comb begin
    term     = '0;
    en       = '0;
    nxt_step = cnt;
    for (int i = 0; i < NDIG; i++) begin
      term[i] = ud ? (cnt[i] == dmax(i)) : (cnt[i] == 4'd0);
    end
    en[0] = ce;
    for (int i = 1; i < NDIG; i++) begin
      en[i] = en[i-1] & term[i-1];
    end
    for (int i = 0; i < NDIG; i++) begin
      if (en[i]) begin
        if (ud) nxt_step[i] = term[i] ? 4'd0 : cnt[i] + 4'd1;
        else    nxt_step[i] = term[i] ? dmax(i) : cnt[i] - 4'd1;
      end
    end
  end

  assign rco = &term;

`ifdef TIME_DIGIT_CHAIN_SAT_EN
  logic [NDIG-1:0] nxt_term;

  always_comb begin
    nxt_term = '0;
    for (int i = 0; i < NDIG; i++) begin
      nxt_term[i] = ud ? (nxt_step[i] == dmax(i)) : (nxt_step[i] == 4'd0);
    end
  end
`endif

  // State register: rst > clr > ld > ce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      wrap_r <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      wrap_r <= 1'b0;
    end else if (ld) begin
      for (int i = 0; i < NDIG; i++) begin
        cnt[i] <= clamp(din[4*i +: 4], i);
      end
      wrap_r <= 1'b0;
    end else begin
`ifdef TIME_DIGIT_CHAIN_SAT_EN
      if (ce && !rco) cnt <= nxt_step;
      wrap_r <= ce & ~rco & (&nxt_term);
`else
      if (ce) cnt <= nxt_step;
      wrap_r <= ce & rco;
`endif
    end
  end

  assign q      = cnt;
  assign wrap_p = wrap_r;

endmodule

// File: tb/tb_time_digit_chain.sv
// Randomized and directed bench for time_digit_chain against a mixed-radix integer model.
module tb_time_digit_chain;

  // Layout with every tens digit mod-6, matching the directed literal values used below
  localparam int         NDIG = 6;
  localparam logic [5:0] MASK = 6'b101010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b0;
  logic        ud  = 1'b1;
  logic        clr = 1'b0;
  logic        ld  = 1'b0;
  logic [23:0] din = '0;
  logic [23:0] q;
  logic        rco;
  logic        wrap_p;

  int  n_chk  = 0;
  int  n_fail = 0;
  int  mv     = 0;
  bit  mw     = 1'b0;
  bit  chk_on = 1'b0;

  time_digit_chain #(.NDIG(NDIG), .RADIX6_MASK(MASK)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ud(ud), .clr(clr), .ld(ld),
    .din(din), .q(q), .rco(rco), .wrap_p(wrap_p)
  );

  always #5 clk = ~clk;

  function automatic int radix(input int i);
    return MASK[i] ? 6 : 10;
  endfunction

  function automatic int modulus();
    int m = 1;
    for (int i = 0; i < NDIG; i++) m = m * radix(i);
    return m;
  endfunction

  // Digits (clamped) to a single mixed-radix integer
  function automatic int to_val(input logic [23:0] d);
    int v = 0;
    int w = 1;
    for (int i = 0; i < NDIG; i++) begin
      int dig = int'(d[4*i +: 4]);
      if (dig > radix(i) - 1) dig = radix(i) - 1;
      v = v + dig * w;
      w = w * radix(i);
    end
    return v;
  endfunction

  function automatic logic [23:0] to_q(input int v);
    logic [23:0] r = '0;
    int x = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % radix(i));
      x = x / radix(i);
    end
    return r;
  endfunction

  function automatic bit at_term(input int v, input bit u);
    return u ? (v == modulus() - 1) : (v == 0);
  endfunction

  function automatic int nxt_val(input int v, input bit u);
`ifdef TIME_DIGIT_CHAIN_SAT_EN
    if (at_term(v, u)) return v;
    return u ? v + 1 : v - 1;
`else
    return u ? (v + 1) % modulus() : (v + modulus() - 1) % modulus();
`endif
  endfunction

  function automatic bit nxt_wrap(input int v, input bit u);
`ifdef TIME_DIGIT_CHAIN_SAT_EN
    if (at_term(v, u)) return 1'b0;
    return at_term(u ? v + 1 : v - 1, u);
`else
    return at_term(v, u);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  always @(posedge clk or posedge rst) begin
    if (rst)      begin mv <= 0;           mw <= 1'b0; end
    else if (clr) begin mv <= 0;           mw <= 1'b0; end
    else if (ld)  begin mv <= to_val(din); mw <= 1'b0; end
    else if (ce)  begin mv <= nxt_val(mv, ud); mw <= nxt_wrap(mv, ud); end
    else          mw <= 1'b0;
  end

  // Per-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("q", 32'(q), 32'(to_q(mv)));
      chk("wrap_p", 32'(wrap_p), 32'(mw));
      chk("rco", 32'(rco), 32'(at_term(mv, ud)));
    end
  end

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [23:0] v);
    ld = 1'b1; din = v; ce = 1'b0; clr = 1'b0;
    sample();
    ld = 1'b0;
  endtask

  initial begin
    // Model pins
    chk("model_clamp", 32'(to_q(to_val(24'h9F9F9F))), 32'h595959);
    chk("model_up", 32'(to_q(nxt_val(to_val(24'h005959), 1'b1))), 32'h010000);
    chk("model_down", 32'(to_q(nxt_val(to_val(24'h010000), 1'b0))), 32'h005959);

    repeat (2) sample();
    rst = 1'b0;
    chk_on = 1'b1;

    // Asynchronous reset mid-count
    ud = 1'b1; ce = 1'b1;
    repeat (5) sample();
    chk("pre_rst_q", 32'(q), 32'h000005);
    rst = 1'b1;
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_wrap", 32'(wrap_p), 32'h0);
    chk("rst_rco_up", 32'(rco), 32'h0);
    ud = 1'b0;
    #1;
    chk("rst_rco_dn", 32'(rco), 32'h1);
    sample();
    rst = 1'b0; ce = 1'b0;

    // Up-count carry and full-chain wrap
    load(24'h005959);
    ud = 1'b1; ce = 1'b1;
    sample();
    ce = 1'b0;
    chk("carry_q", 32'(q), 32'h010000);
    chk("carry_wrap", 32'(wrap_p), 32'h0);
    load(24'h595958);
    ce = 1'b1;
    sample();
    chk("up_q1", 32'(q), 32'h595959);
`ifdef TIME_DIGIT_CHAIN_SAT_EN
    chk("up_w1", 32'(wrap_p), 32'h1);
    sample();
    ce = 1'b0;
    chk("up_q2", 32'(q), 32'h595959);
    chk("up_w2", 32'(wrap_p), 32'h0);
`else
    chk("up_w1", 32'(wrap_p), 32'h0);
    sample();
    ce = 1'b0;
    chk("up_q2", 32'(q), 32'h000000);
    chk("up_w2", 32'(wrap_p), 32'h1);
`endif
    sample();
    chk("up_w3", 32'(wrap_p), 32'h0);

    // Down-count borrow and wrap from zero
    load(24'h010000);
    ud = 1'b0; ce = 1'b1;
    sample();
    ce = 1'b0;
    chk("borrow_q", 32'(q), 32'h005959);
    load(24'h000000);
    ce = 1'b1;
    sample();
    ce = 1'b0;
`ifdef TIME_DIGIT_CHAIN_SAT_EN
    chk("dnwrap_q", 32'(q), 32'h000000);
    chk("dnwrap_w", 32'(wrap_p), 32'h0);
`else
    chk("dnwrap_q", 32'(q), 32'h595959);
    chk("dnwrap_w", 32'(wrap_p), 32'h1);
`endif

    // Load clamp beats ce; clr beats ld
    ud = 1'b1; ld = 1'b1; ce = 1'b1; din = 24'h9F9F9F;
    sample();
    chk("clamp_q", 32'(q), 32'h595959);
    chk("clamp_w", 32'(wrap_p), 32'h0);
    clr = 1'b1; ld = 1'b1; ce = 1'b0; din = 24'h123454;
    sample();
    clr = 1'b0; ld = 1'b0;
    chk("clr_ld_q", 32'(q), 32'h0);

    // Direction change mid-run
    load(24'h000009);
    ud = 1'b1;
    #1;
    chk("dir_rco", 32'(rco), 32'h0);
    ud = 1'b0; ce = 1'b1;
    sample();
    ce = 1'b0;
    chk("dir_q", 32'(q), 32'h000008);
    chk("dir_w", 32'(wrap_p), 32'h0);

`ifdef TIME_DIGIT_CHAIN_SAT_EN
    // Saturating countdown
    load(24'h000002);
    ud = 1'b0; ce = 1'b1;
    sample();
    chk("sat_q1", 32'(q), 32'h1);
    chk("sat_w1", 32'(wrap_p), 32'h0);
    sample();
    chk("sat_q2", 32'(q), 32'h0);
    chk("sat_w2", 32'(wrap_p), 32'h1);
    chk("sat_rco2", 32'(rco), 32'h1);
    for (int k = 3; k <= 4; k++) begin
      sample();
      chk("sat_qh", 32'(q), 32'h0);
      chk("sat_wh", 32'(wrap_p), 32'h0);
      chk("sat_rcoh", 32'(rco), 32'h1);
    end
    ce = 1'b0;
`endif

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      ce  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) ud = ~ud;
      clr = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      din = 24'($urandom);
      if ($urandom_range(0, 3) == 0) din = to_q($urandom_range(0, modulus() - 1));
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        chk("rand_rst_q", 32'(q), 32'h0);
        chk("rand_rst_w", 32'(wrap_p), 32'h0);
      end
      sample();
    end
    rst = 1'b0; ce = 1'b0; clr = 1'b0; ld = 1'b0;
    repeat (2) sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
